axis_bitop_fifo: RTL and testbench

AXIS_BITOP_FIFO -- requirements
Module: axis_bitop_fifo

---
 rtl/axis_bitop_fifo.sv | 177 +++++++++++++++++
 tb/tb_axis_bitop_fifo.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_bitop_fifo.sv
// AXI4-Stream bit-operation FIFO: per-packet transform at write, first-word-fall-through buffer.
// Optional packet counter output enabled by defining AXIS_BITOP_PKTCNT_EN.
module axis_bitop_fifo #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned START_COUNT = 32
) (
    input  logic                            axis_aclk,
    input  logic                            axis_areset,
    input  logic [DATA_WIDTH-1:0]           s00_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]         s00_axis_tstrb,
    input  logic                            s00_axis_tlast,
    input  logic                            s00_axis_tvalid,
    output logic                            s00_axis_tready,
    output logic [DATA_WIDTH-1:0]           m00_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]         m00_axis_tstrb,
    output logic                            m00_axis_tlast,
    output logic                            m00_axis_tvalid,
    input  logic                            m00_axis_tready,
    input  logic [1:0]                      op_mode,
    input  logic [DATA_WIDTH-1:0]           op_mask,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level
`ifdef AXIS_BITOP_PKTCNT_EN
    ,
    output logic [31:0]                     pkt_count
`endif
);

    localparam int unsigned SW = DATA_WIDTH / 8;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam int unsigned CW = 16;

    typedef struct packed {
        logic                  last;
        logic [SW-1:0]         strb;
        logic [DATA_WIDTH-1:0] data;
    } beat_t;

    typedef enum logic {
        WAIT_START = 1'b0,
        RUN        = 1'b1
    } state_t;

    function automatic logic [DATA_WIDTH-1:0] bit_rev(input logic [DATA_WIDTH-1:0] d);
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < int'(DATA_WIDTH); i++) begin
            r[i] = d[int'(DATA_WIDTH) - 1 - i];
        end
        return r;
    endfunction

    state_t                r_state;
    state_t                w_state_next;
    logic [CW-1:0]         r_start_cnt;
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [PW-1:0]         w_rd_next;
    logic [LW-1:0]         r_level;
    logic [LW-1:0]         w_level_next;
    logic                  r_s_tready;
    logic                  r_m_tvalid;
    beat_t                 r_m_beat;
    beat_t                 w_wr_beat;
    beat_t                 w_head_beat;
    beat_t                 r_mem [FIFO_DEPTH];
    logic                  r_pkt_start;
    logic [1:0]            r_mode;
    logic [DATA_WIDTH-1:0] r_mask;
    logic [1:0]            w_mode;
    logic [DATA_WIDTH-1:0] w_mask;
    logic                  w_push;
    logic                  w_pop;

    // Start-up delay state register
    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            r_state <= WAIT_START;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            WAIT_START: if (r_start_cnt == CW'(START_COUNT - 1)) w_state_next = RUN;
            RUN:        w_state_next = RUN;
            default:    w_state_next = WAIT_START;
        endcase
    end

    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            r_start_cnt <= '0;
        end else if (r_state == WAIT_START && r_start_cnt != CW'(START_COUNT - 1)) begin
            r_start_cnt <= r_start_cnt + CW'(1);
        end
    end

    // First beat of a packet uses the live mode/mask; later beats use the latched copy
    always_comb begin
        w_mode         = r_pkt_start ? op_mode : r_mode;
        w_mask         = r_pkt_start ? op_mask : r_mask;
        w_wr_beat.last = s00_axis_tlast;
        w_wr_beat.strb = s00_axis_tstrb;
        case (w_mode)
            2'b00: w_wr_beat.data = s00_axis_tdata;
            2'b01: w_wr_beat.data = ~s00_axis_tdata;
            2'b10: w_wr_beat.data = s00_axis_tdata ^ w_mask;
            2'b11: w_wr_beat.data = bit_rev(s00_axis_tdata);
            default: w_wr_beat.data = s00_axis_tdata;
        endcase
    end

    assign w_push       = s00_axis_tvalid && r_s_tready;
    assign w_pop        = r_m_tvalid && m00_axis_tready;
    assign w_level_next = r_level + LW'(w_push) - LW'(w_pop);
    assign w_rd_next    = w_pop ? r_rd_ptr + PW'(1) : r_rd_ptr;
    // Bypass the memory when the beat being written becomes the new head
    assign w_head_beat  = (w_push && (r_wr_ptr == w_rd_next)) ? w_wr_beat : r_mem[w_rd_next];

    always_ff @(posedge axis_aclk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_wr_beat;
    end

    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_s_tready  <= 1'b0;
            r_m_tvalid  <= 1'b0;
            r_m_beat    <= '0;
            r_pkt_start <= 1'b1;
            r_mode      <= 2'b00;
            r_mask      <= '0;
        end else begin
            r_rd_ptr   <= w_rd_next;
            r_level    <= w_level_next;
            r_s_tready <= (w_state_next == RUN) && (w_level_next < LW'(FIFO_DEPTH));
            r_m_tvalid <= (w_level_next != '0);
            if (w_level_next != '0) r_m_beat <= w_head_beat;
            if (w_push) begin
                r_wr_ptr    <= r_wr_ptr + PW'(1);
                r_pkt_start <= s00_axis_tlast;
                if (r_pkt_start) begin
                    r_mode <= op_mode;
                    r_mask <= op_mask;
                end
            end
        end
    end

    assign s00_axis_tready = r_s_tready;
    assign m00_axis_tvalid = r_m_tvalid;
    assign m00_axis_tdata  = r_m_beat.data;
    assign m00_axis_tstrb  = r_m_beat.strb;
    assign m00_axis_tlast  = r_m_beat.last;
    assign fifo_level      = r_level;

`ifdef AXIS_BITOP_PKTCNT_EN
    logic [31:0] r_pkt_count;

    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            r_pkt_count <= '0;
        end else if (w_pop && r_m_beat.last) begin
            r_pkt_count <= r_pkt_count + 32'd1;
        end
    end

    assign pkt_count = r_pkt_count;
`endif

endmodule

// File: tb/tb_axis_bitop_fifo.sv
// Directed bench for axis_bitop_fifo (default parameters).
module tb_axis_bitop_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_tdata = '0;
    logic [3:0]  s_tstrb = 4'hF;
    logic        s_tlast = 1'b0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic [3:0]  m_tstrb;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic [1:0]  op_mode = 2'b00;
    logic [31:0] op_mask = '0;
    logic [4:0]  fifo_level;
`ifdef AXIS_BITOP_PKTCNT_EN
    logic [31:0] pkt_count;
`endif

    axis_bitop_fifo dut (
        .axis_aclk       (clk),
        .axis_areset     (rst),
        .s00_axis_tdata  (s_tdata),
        .s00_axis_tstrb  (s_tstrb),
        .s00_axis_tlast  (s_tlast),
        .s00_axis_tvalid (s_tvalid),
        .s00_axis_tready (s_tready),
        .m00_axis_tdata  (m_tdata),
        .m00_axis_tstrb  (m_tstrb),
        .m00_axis_tlast  (m_tlast),
        .m00_axis_tvalid (m_tvalid),
        .m00_axis_tready (m_tready),
        .op_mode         (op_mode),
        .op_mask         (op_mask),
        .fifo_level      (fifo_level)
`ifdef AXIS_BITOP_PKTCNT_EN
        ,
        .pkt_count       (pkt_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] mask;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [6];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one beat, let it be accepted, then check it appears at the output one cycle later
    task automatic send_beat(input logic [31:0] data, input logic [3:0] strb, input logic last,
                             input logic [1:0] mode, input logic [31:0] mask,
                             input logic [31:0] exp_data, input string name);
        s_tdata  = data;
        s_tstrb  = strb;
        s_tlast  = last;
        op_mode  = mode;
        op_mask  = mask;
        s_tvalid = 1'b1;
        check({name, " s_tready"}, 32'(s_tready), 32'd1);
        tick();
        check({name, " m_tvalid"}, 32'(m_tvalid), 32'd1);
        check({name, " m_tdata"}, m_tdata, exp_data);
        check({name, " m_tstrb"}, 32'(m_tstrb), 32'(strb));
        check({name, " m_tlast"}, 32'(m_tlast), 32'(last));
    endtask

    task automatic idle(input string name);
        s_tvalid = 1'b0;
        tick();
        check({name, " drained"}, 32'(m_tvalid), 32'd0);
    endtask

    // Count cycles with tready low after reset release; bounded
    task automatic wait_start(input string name, output int stale);
        int n;
        n = 0;
        stale = 0;
        while (s_tready !== 1'b1 && n < 100) begin
            if (m_tvalid) stale++;
            n++;
            tick();
        end
        check({name, " startup cycles"}, 32'(n), 32'd32);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc;
        int exp_v;
        int cyc;
        int stale;
        logic pushed;

        vecs[0] = '{2'b00, 32'h0,        32'hDEADBEEF, 4'hF, 32'hDEADBEEF};
        vecs[1] = '{2'b01, 32'h0,        32'h0F0F0000, 4'hF, 32'hF0F0FFFF};
        vecs[2] = '{2'b10, 32'hA5A5A5A5, 32'hFFFF0000, 4'hC, 32'h5A5AA5A5};
        vecs[3] = '{2'b11, 32'h0,        32'h00000001, 4'hF, 32'h80000000};
        vecs[4] = '{2'b11, 32'hFFFFFFFF, 32'h12345678, 4'h1, 32'h1E6A2C48};
        vecs[5] = '{2'b10, 32'h0,        32'h00000055, 4'h3, 32'h00000055};

        // Reset state
        tick();
        tick();
        check("rst s_tready", 32'(s_tready), 32'd0);
        check("rst m_tvalid", 32'(m_tvalid), 32'd0);
        check("rst fifo_level", 32'(fifo_level), 32'd0);
        check("rst m_tdata", m_tdata, 32'd0);

        // Start-up delay with tvalid held high
        rst      = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = 32'h12345678;
        s_tlast  = 1'b1;
        wait_start("boot", stale);
        tick();
        s_tvalid = 1'b0;
        check("first accept m_tvalid", 32'(m_tvalid), 32'd1);
        check("first accept m_tdata", m_tdata, 32'h12345678);
        check("first accept level", 32'(fifo_level), 32'd1);
        tick();
        check("first accept drained level", 32'(fifo_level), 32'd0);

        // Single-beat packets from the table
        for (int i = 0; i < 6; i++) begin
            send_beat(vecs[i].data, vecs[i].strb, 1'b1, vecs[i].mode, vecs[i].mask,
                      vecs[i].exp_data, $sformatf("vec%0d", i));
        end
        idle("vec");

        // Invert, two-beat packet back to back
        send_beat(32'h00000000, 4'hF, 1'b0, 2'b01, 32'h0, 32'hFFFFFFFF, "inv b0");
        send_beat(32'hFFFF0000, 4'hF, 1'b1, 2'b01, 32'h0, 32'h0000FFFF, "inv b1");
        idle("inv");

        // Mode change mid-packet takes effect only at the next packet
        send_beat(32'h00000000, 4'hF, 1'b0, 2'b10, 32'hA5A5A5A5, 32'hA5A5A5A5, "latch b0");
        send_beat(32'h11111111, 4'hF, 1'b0, 2'b11, 32'h0,        32'hB4B4B4B4, "latch b1");
        send_beat(32'h22222222, 4'hF, 1'b1, 2'b11, 32'h0,        32'h87878787, "latch b2");
        send_beat(32'h00000001, 4'hF, 1'b1, 2'b11, 32'h0,        32'h80000000, "latch next");
        idle("latch");

        // Fill to full with the sink stalled, then drain in order
        op_mode  = 2'b00;
        m_tready = 1'b0;
        acc      = 0;
        for (int i = 0; i < 17; i++) begin
            s_tdata  = 32'(acc);
            s_tlast  = (acc == 16);
            s_tvalid = 1'b1;
            if (s_tready) acc++;
            tick();
        end
        check("full accepted", 32'(acc), 32'd16);
        check("full level", 32'(fifo_level), 32'd16);
        check("full s_tready", 32'(s_tready), 32'd0);
        check("full head", m_tdata, 32'd0);
        m_tready = 1'b1;
        exp_v    = 0;
        cyc      = 0;
        while (exp_v < 17 && cyc < 60) begin
            if (m_tvalid) begin
                check($sformatf("drain beat %0d", exp_v), m_tdata, 32'(exp_v));
                exp_v++;
            end
            pushed = s_tvalid && s_tready;
            tick();
            if (pushed) s_tvalid = 1'b0;
            cyc++;
        end
        check("drain count", 32'(exp_v), 32'd17);
        check("drain level", 32'(fifo_level), 32'd0);

        // Reset with buffered beats
        m_tready = 1'b0;
        s_tlast  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_tdata  = 32'hC0DE0000 + 32'(i);
            s_tvalid = 1'b1;
            tick();
        end
        s_tvalid = 1'b0;
        check("pre-reset level", 32'(fifo_level), 32'd5);
        #2 rst = 1'b1;
        #1;
        check("async rst m_tvalid", 32'(m_tvalid), 32'd0);
        check("async rst level", 32'(fifo_level), 32'd0);
        check("async rst s_tready", 32'(s_tready), 32'd0);
        tick();
        rst      = 1'b0;
        m_tready = 1'b1;
        wait_start("reboot", stale);
        check("no stale beat", 32'(stale), 32'd0);
        check("reboot m_tvalid", 32'(m_tvalid), 32'd0);

`ifdef AXIS_BITOP_PKTCNT_EN
        send_beat(32'h1, 4'hF, 1'b1, 2'b00, 32'h0, 32'h1, "pkt0");
        send_beat(32'h2, 4'hF, 1'b0, 2'b00, 32'h0, 32'h2, "pkt1 b0");
        send_beat(32'h3, 4'hF, 1'b1, 2'b00, 32'h0, 32'h3, "pkt1 b1");
        send_beat(32'h4, 4'hF, 1'b1, 2'b00, 32'h0, 32'h4, "pkt2");
        idle("pkt");
        check("pkt_count", pkt_count, 32'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
